sssp_apply: RTL and testbench
=============================

# sssp_apply

Gather/apply stage of the SSSP edge-centric engine: consumes the 64-bit relaxation updates `{dst, weight}` produced by the scatter pipelines and folds them into a local vertex partition held in block RAM. An update wins if its weight is strictly lower than the stored weight; the vertex is then rewritten with the new weight and level `current_level+1`. The partition is loaded from cache lines before a pass and streamed back out as cache lines after it.

## Interface
Parameters:
- `ADDR_W`, 8, log2 of the vertex count in the partition; must be ≥ 4. The partition holds 2^(ADDR_W-3) lines of 8 vertices.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `control`  in  2  0 idle, 1 load, 2 apply, 3 export
- `word_in`  in  512  load line; vertex i in bits [64i+63:64i] = {16'h0, level[15:0], weight[31:0]}
- `word_in_valid`  in  1  load line valid
- `w_addr`  in  32  vertex index of the first vertex in `word_in`; bits [2:0] ignored
- `upd_in`  in  64  update {dst[63:32], weight[31:0]}
- `upd_valid`  in  1  update valid
- `upd_ready`  out  1  update accepted when `upd_valid & upd_ready`
- `last_input_in`  in  1  qualifies the final update of a pass
- `current_level`  in  16  level of the current pass
- `out_line`  out  512  exported line, same format as `word_in`
- `out_addr`  out  32  vertex index of `out_line` lane 0
- `out_valid`  out  1  export line valid
- `out_ready`  in  1  export sink ready
- `apply_done`  out  1  one-cycle pulse after the last update has been written
- `export_done`  out  1  high after the last line is accepted; cleared when `control` leaves 3
- `changed`  out  1  sticky: at least one vertex improved since the last load
- `applied_count`, `dropped_count`  out  32 each  statistics counters

## Operation
- RAM: lines of 8×64 b, per-lane write enable, 1-cycle read latency, read-first on a same-address collision.
- Load (`control==1 & word_in_valid`):
  - Writes all 8 lanes at line `w_addr[ADDR_W-1:3]`.
  - Captures `prefix <= w_addr[31:ADDR_W]`.
  - Clears `changed`.
- Apply (`control==2`):
  - `upd_ready=1`; no stalls.
  - Stage A, on accept: issue a read of line `dst[ADDR_W-1:3]` and latch the update.
  - Stage B: select lane `dst[2:0]`. If the previous cycle's write hit the same vertex, forward the written value instead of RAM data.
  - Drop the update (`dropped_count++`) if `dst[31:ADDR_W] != prefix`.
  - Otherwise, if `upd.weight < stored.weight` (unsigned), write `{level=current_level+1 (16-bit wrap), weight=upd.weight}`, then `applied_count++` and set `changed`.
  - Equal or greater weight: no write, no count.
- Last update: an accepted update with `last_input_in=1` pulses `apply_done` in the cycle after its stage B.
- Leaving apply mode: `upd_ready` drops the same cycle. Updates already in flight still complete.
- FSM states: IDLE, LOAD, APPLY, EXPORT, EXP_DONE.
  - Entered states follow `control`.
  - EXPORT is entered on `control` becoming 3. It walks lines 0..2^(ADDR_W-3)-1, with `out_addr = {prefix, line, 3'b000}`.
  - After the final handshake the FSM goes to EXP_DONE, where `export_done=1`.
  - `control!=3` returns the FSM to IDLE and aborts an export.
- Export handshake: `out_line`/`out_addr` are held stable while `out_valid & !out_ready`. A two-entry output buffer absorbs the RAM read latency.

## Timing
- Reset values: `upd_ready` 0, `out_valid` 0, `out_line` 0, `out_addr` 0, `apply_done` 0, `export_done` 0, `changed` 0, counters 0, FSM IDLE, prefix 0. RAM contents are not cleared.
- Update latency: accepted at cycle t, RAM written at the end of t+1. A read of the same vertex at t+2 sees the new value.
- Back-to-back updates to the same `dst` at t and t+1 resolve correctly through forwarding.
- Export: first `out_valid` 2 cycles after entering EXPORT. With `out_ready` held high, one line per cycle.
- Reset mid-pass flushes the pipeline and output buffer. Any write from stage B is suppressed in the reset cycle.
- Counters saturate at 32'hFFFF_FFFF.

## Configuration
- `SSSP_APPLY_STATS_EN` defined: `applied_count` and `dropped_count` are live.
- Not defined: both counters are tied to 0 and their logic is not built. `changed` is unaffected.

## Test plan
- Load 32 lines at `w_addr=0x1200+8k` with all weights 1000 and level 0. Export with `out_ready=1` -> 32 consecutive lines, `out_addr` 0x1200..0x12F8, data identical to load, then `export_done=1`.
- Apply `{0x1205,300}` at `current_level=4` -> vertex 5 becomes {5,300}; `applied_count=1`; `changed=1`.
- Apply `{0x1207,200}` then `{0x1207,150}` on consecutive cycles, then `{0x1207,180}` -> final weight 150, level `current_level+1`; `applied_count=2`.
- Apply `{0x1307,1}` (prefix mismatch) and `{0x1208,1000}` (equal weight) -> no RAM change; `dropped_count=1`; `applied_count=0`.
- Export with `out_ready` toggled 1,0,0,1 -> `out_line`/`out_addr` stable during stalls; no line lost or duplicated.
- Assert `rst` one cycle after an update is accepted -> vertex unchanged; all outputs at reset values next cycle.

Source files
------------

// File: rtl/sssp_apply.sv
// sssp_apply: SSSP gather/apply stage folding {dst,weight} updates into a BRAM vertex partition; SSSP_APPLY_STATS_EN enables the statistics counters.
module sssp_apply #(
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   control,
  input  logic [511:0] word_in,
  input  logic         word_in_valid,
  input  logic [31:0]  w_addr,
  input  logic [63:0]  upd_in,
  input  logic         upd_valid,
  output logic         upd_ready,
  input  logic         last_input_in,
  input  logic [15:0]  current_level,
  output logic [511:0] out_line,
  output logic [31:0]  out_addr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         apply_done,
  output logic         export_done,
  output logic         changed,
  output logic [31:0]  applied_count,
  output logic [31:0]  dropped_count
);
  localparam int LW = ADDR_W - 3;
  localparam int LINES = 1 << LW;
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, APPLY = 3'd2, EXPORT = 3'd3, EXP_DONE = 3'd4;
  logic [511:0] mem [LINES];
  logic [511:0] rd_data, wd, buf0, buf1;
  logic [LW-1:0] rd_addr, wr_addr, pcnt;
  logic [LW:0] iss;
  logic [7:0] we;
  logic [2:0] state, state_nxt, pend;
  logic [1:0] occ;
  logic [31-ADDR_W:0] prefix;
  logic accept, load, a_v, a_last, fw_v, b_wr, b_match, exp_issue, exp_rv, push, pop, unused;
  logic [31:0] a_dst, a_w;
  logic [ADDR_W-1:0] fw_idx;
  logic [63:0] fw_val, ram_lane, stored, b_val;
  assign upd_ready = control == 2'd2 && !rst;
  assign accept = upd_valid && upd_ready;
  assign load = control == 2'd1 && word_in_valid;
  assign ram_lane = rd_data[{a_dst[2:0], 6'd0} +: 64];
  // the previous cycle's write is not yet visible in the registered RAM read
  assign stored = fw_v && fw_idx == a_dst[ADDR_W-1:0] ? fw_val : ram_lane;
  assign b_match = a_dst[31:ADDR_W] == prefix;
  assign b_val = {16'h0, current_level + 16'd1, a_w};
  assign b_wr = a_v && b_match && a_w < stored[31:0] && !rst;
  assign wr_addr = b_wr ? a_dst[ADDR_W-1:3] : w_addr[ADDR_W-1:3];
  assign wd = b_wr ? {8{b_val}} : word_in;
  assign we = b_wr ? 8'd1 << a_dst[2:0] : {8{load}};
  assign rd_addr = exp_issue ? iss[LW-1:0] : upd_in[ADDR_W+31:35];
  assign unused = ^{w_addr[2:0], stored[63:32]};
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
    for (int l = 0; l < 8; l++)
      if (we[l]) mem[wr_addr][l*64 +: 64] <= wd[l*64 +: 64];
  end
  always_ff @(posedge clk) begin
    a_dst <= upd_in[63:32];
    a_w <= upd_in[31:0];
    fw_idx <= a_dst[ADDR_W-1:0];
    fw_val <= b_val;
    if (rst) begin
      a_v <= 1'b0;
      a_last <= 1'b0;
      fw_v <= 1'b0;
      apply_done <= 1'b0;
      changed <= 1'b0;
      prefix <= '0;
    end else begin
      a_v <= accept;
      a_last <= accept && last_input_in;
      fw_v <= b_wr;
      apply_done <= a_v && a_last;
      changed <= b_wr || (changed && !load);
      if (load) prefix <= w_addr[31:ADDR_W];
    end
  end
  assign pop = out_valid && out_ready;
  assign push = exp_rv;
  assign pend = {1'b0, occ} + {2'b0, exp_rv};
  // reads in flight plus buffered lines never exceed the two buffer slots
  assign exp_issue = state == EXPORT && control == 2'd3 && !iss[LW] && pend < 3'd2 + {2'b0, pop};
  assign state_nxt = control == 2'd0 ? IDLE :
                     control == 2'd1 ? LOAD :
                     control == 2'd2 ? APPLY :
                     state == EXP_DONE || (state == EXPORT && pop && &pcnt) ? EXP_DONE : EXPORT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      occ <= '0;
      exp_rv <= 1'b0;
      iss <= '0;
      pcnt <= '0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      state <= state_nxt;
      exp_rv <= exp_issue;
      if (state_nxt != EXPORT) begin
        occ <= '0;
        iss <= '0;
        pcnt <= '0;
      end else begin
        iss <= iss + (LW+1)'(exp_issue);
        pcnt <= pcnt + LW'(pop);
        occ <= occ + 2'(push) - 2'(pop);
        if (pop) buf0 <= occ == 2'd2 ? buf1 : rd_data;
        else if (push && occ == 2'd0) buf0 <= rd_data;
        if (push && occ == 2'd1 && !pop) buf1 <= rd_data;
      end
    end
  end
  assign out_valid = occ != 2'd0;
  assign out_line = buf0;
  assign out_addr = {prefix, pcnt, 3'b000};
  assign export_done = state == EXP_DONE && control == 2'd3;
`ifdef SSSP_APPLY_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      applied_count <= '0;
      dropped_count <= '0;
    end else begin
      if (b_wr && !(&applied_count)) applied_count <= applied_count + 32'd1;
      if (a_v && !b_match && !(&dropped_count)) dropped_count <= dropped_count + 32'd1;
    end
  end
`else
  assign applied_count = '0;
  assign dropped_count = '0;
`endif
endmodule

// File: tb/tb_sssp_apply.sv
// tb_sssp_apply: randomized scoreboard bench for sssp_apply against a vertex-array reference model.
module tb_sssp_apply;
  localparam int NL = 32;
  logic clk = 1'b0, rst;
  logic [1:0] control;
  logic [511:0] word_in, out_line;
  logic word_in_valid, upd_valid, upd_ready, last_input_in, out_valid, out_ready;
  logic apply_done, export_done, changed;
  logic [31:0] w_addr, out_addr, applied_count, dropped_count;
  logic [63:0] upd_in;
  logic [15:0] current_level;
  always #5 clk = ~clk;
  sssp_apply dut (
    .clk(clk), .rst(rst), .control(control), .word_in(word_in), .word_in_valid(word_in_valid),
    .w_addr(w_addr), .upd_in(upd_in), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .last_input_in(last_input_in), .current_level(current_level), .out_line(out_line),
    .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready), .apply_done(apply_done),
    .export_done(export_done), .changed(changed), .applied_count(applied_count),
    .dropped_count(dropped_count)
  );
  int checks = 0, errors = 0, cyc = 0;
  logic [63:0] mm [256];
  logic [23:0] mprefix = '0;
  logic mchanged = 1'b0;
  logic [31:0] mapp = '0, mdrop = '0;
  logic [543:0] exp_q [$];
  int done_q [$];
  logic stall_p = 1'b0;
  logic [543:0] held;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [543:0] act, input logic [543:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [511:0] mline(input int l);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[i*64 +: 64] = mm[l*8+i];
    return r;
  endfunction
  always @(negedge clk) begin
    if (rst) stall_p = 1'b0;
    else begin
      if (out_valid) begin
        if (stall_p) chk("hold", {out_addr, out_line}, held);
        if (out_ready) begin
          if (exp_q.size() == 0) chk("out_valid unexpected", out_valid, 0);
          else chk("line", {out_addr, out_line}, exp_q.pop_front());
        end
      end
      stall_p = out_valid && !out_ready;
      held = {out_addr, out_line};
      if (apply_done) begin
        if (done_q.size() == 0) chk("apply_done unexpected", apply_done, 0);
        else chk("apply_done cycle", cyc, done_q.pop_front());
      end
    end
  end
  task automatic check_reset;
    chk("rst upd_ready", upd_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_line", out_line, 0);
    chk("rst out_addr", out_addr, 0);
    chk("rst apply_done", apply_done, 0);
    chk("rst export_done", export_done, 0);
    chk("rst changed", changed, 0);
    chk("rst applied_count", applied_count, 0);
    chk("rst dropped_count", dropped_count, 0);
  endtask
  task automatic check_status;
    chk("changed", changed, mchanged);
`ifdef SSSP_APPLY_STATS_EN
    chk("applied_count", applied_count, mapp);
    chk("dropped_count", dropped_count, mdrop);
`else
    chk("applied_count", applied_count, 0);
    chk("dropped_count", dropped_count, 0);
`endif
  endtask
  task automatic load_line(input int l, input logic [31:0] base, input bit rnd);
    logic [63:0] v;
    control = 2'd1;
    w_addr = base + 32'(l * 8);
    for (int i = 0; i < 8; i++) begin
      v = rnd ? {16'h0, 16'($urandom), 32'($urandom_range(0, 2000))} : {16'h0, 16'h0, 32'd1000};
      mm[l*8+i] = v;
      word_in[i*64 +: 64] = v;
    end
    word_in_valid = 1'b1;
    mprefix = w_addr[31:8];
    mchanged = 1'b0;
    tick();
    word_in_valid = 1'b0;
  endtask
  task automatic send(input logic [31:0] dst, input logic [31:0] w, input bit last);
    chk("upd_ready", upd_ready, 1);
    upd_in = {dst, w};
    upd_valid = 1'b1;
    last_input_in = last;
    if (dst[31:8] != mprefix) mdrop++;
    else if (w < mm[dst[7:0]][31:0]) begin
      mm[dst[7:0]] = {16'h0, current_level + 16'd1, w};
      mapp++;
      mchanged = 1'b1;
    end
    if (last) done_q.push_back(cyc + 2);
    tick();
    upd_valid = 1'b0;
    last_input_in = 1'b0;
  endtask
  task automatic do_export(input int mode);
    int k;
    logic [3:0] pat;
    pat = 4'b1001;
    for (int l = 0; l < NL; l++) exp_q.push_back({mprefix, 5'(l), 3'b000, mline(l)});
    out_ready = mode != 2;
    control = 2'd3;
    k = 0;
    while (k < 2000 && !export_done) begin
      tick();
      k++;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[k%4] : 1'($urandom_range(0, 1));
    end
    chk("export_done", export_done, 1);
    if (mode == 0) chk("export cycles", k, NL + 3);
    chk("export lines left", exp_q.size(), 0);
    exp_q.delete();
    control = 2'd0;
    out_ready = 1'b0;
    #1;
    chk("export_done clear", export_done, 0);
    tick();
  endtask
  task automatic burst(input logic [15:0] lvl, input int n);
    logic [31:0] d, pd;
    pd = 32'h1200;
    current_level = lvl;
    control = 2'd2;
    tick();
    for (int i = 0; i < n; i++) begin
      d = (i > 0 && $urandom_range(0, 2) == 0) ? pd :
          ($urandom_range(0, 9) == 0) ? 32'($urandom) : {24'h000012, 8'($urandom)};
      send(d, 32'($urandom_range(0, 2000)), i == n - 1);
      pd = d;
      if ($urandom_range(0, 4) == 0) tick();
    end
    control = 2'd0;
    #1;
    chk("upd_ready drop", upd_ready, 0);
    repeat (3) tick();
    check_status();
  endtask
  initial begin
    int v;
    rst = 1'b1; control = 2'd2; word_in = '0; word_in_valid = 1'b0; w_addr = '0;
    upd_in = '0; upd_valid = 1'b0; last_input_in = 1'b0; current_level = '0; out_ready = 1'b0;
    repeat (3) tick();
    check_reset();
    rst = 1'b0; control = 2'd0;
    tick();
    for (int l = 0; l < NL; l++) load_line(l, 32'h1200, 1'b0);
    control = 2'd0;
    tick();
    check_status();
    do_export(0);
    current_level = 16'd4;
    control = 2'd2;
    tick();
    send(32'h1205, 32'd300, 1'b0);
    send(32'h1207, 32'd200, 1'b0);
    send(32'h1207, 32'd150, 1'b0);
    send(32'h1207, 32'd180, 1'b0);
    send(32'h1307, 32'd1, 1'b0);
    send(32'h1208, 32'd1000, 1'b1);
    control = 2'd0;
    #1;
    chk("upd_ready drop", upd_ready, 0);
    repeat (3) tick();
    check_status();
    do_export(1);
    load_line(0, 32'h1200, 1'b1);
    control = 2'd0;
    tick();
    check_status();
    for (int l = 0; l < NL; l++) load_line(l, 32'h1200, 1'b1);
    burst(16'hFFFF, 150);
    burst(16'($urandom), 150);
    do_export(2);
    control = 2'd2;
    current_level = 16'd7;
    tick();
    v = 0;
    for (int i = 255; i >= 0; i--) if (mm[i][31:0] != 0) v = i;
    upd_in = {24'h000012, 8'(v), 32'd0};
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    rst = 1'b1;
    control = 2'd0;
    tick();
    check_reset();
    rst = 1'b0;
    mprefix = '0; mchanged = 1'b0; mapp = '0; mdrop = '0;
    tick();
    do_export(2);
    check_status();
    chk("apply_done pending", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
